// File: rtl/cla_wide_add_seq.sv
// ---------------------------------------------------------------------------
// cla_wide_add_seq
//
// Purpose:
//   Wide add/subtract engine that reuses a single 16-bit carry-lookahead
//   slice adder. An operation on WORDS x 16-bit operands is processed one
//   slice per cycle, least-significant slice first. The carry between
//   slices is held in a register.
//
//   Subtraction is computed as a + ~b + 1. B is inverted when the request
//   is accepted, and the carry register is seeded with op_sub.
//
// Ports:
//   clk        in   rising-edge system clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request valid (a, b, op_sub stable while high)
//   in_ready   out  sequencer idle and able to accept a request
//   op_sub     in   0: a+b, 1: a-b
//   a, b       in   W-bit operands, W = 16*WORDS
//   out_valid  out  result valid (held until out_ready)
//   out_ready  in   consumer accepts the result
//   sum        out  W-bit result
//   cout       out  carry out of the MSB (subtract: 1 = no borrow)
//   ovf        out  signed overflow
//   busy       out  slices are being processed
//
// Every handshake output is decoded from registered state only. No
// combinational path exists from in_valid to in_ready, or from out_ready
// to out_valid.
// ---------------------------------------------------------------------------
module cla_wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);

  localparam int W = 16 * WORDS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(WORDS - 1);

  // 16-bit carry-lookahead adder.
  //   - Four 4-bit groups each form a group propagate and a group
  //     generate term.
  //   - C4/C8/C12/C16 are produced from those group terms and the
  //     carry-in.
  //   - Carries inside each group ripple from that group's lookahead
  //     carry.
  //   - Return value is {C16, C15, sum[15:0]}. C15 is the carry into
  //     bit 15, which is needed for signed overflow.
  function automatic logic [17:0] cla16(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic        cin);
    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;
    logic [16:0] c;
    g = x & y;
    p = x ^ y;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[16] = gc[4];
    return {c[16], c[15], p ^ c[15:0]};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic         carry_q, carry_d;
  logic         c_msb_q, c_msb_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] sum_q, sum_d;

  logic [15:0]  a_sl;
  logic [15:0]  b_sl;
  logic [17:0]  slice_res;

  // Operand slice select for the current index
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == 4'(i)) begin
        a_sl = a_q[16*i +: 16];
        b_sl = b_q[16*i +: 16];
      end
    end
  end

  assign slice_res = cla16(a_sl, b_sl, carry_q);

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub;
          idx_d   = '0;
          // Slices not yet processed must read as zero during RUN.
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < WORDS; i++) begin
          if (idx_q == 4'(i)) begin
            sum_d[16*i +: 16] = slice_res[15:0];
          end
        end
        carry_d = slice_res[17];
        c_msb_d = slice_res[16];
        idx_d   = idx_q + 4'd1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  // In DONE the carry register holds the final carry out of the MSB slice.
  // Signed overflow is present when the carry into bit W-1 differs from the
  // carry out of it.
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;
  assign ovf       = c_msb_q ^ carry_q;

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// ---------------------------------------------------------------------------
// tb_cla_wide_add_seq
//
// Two sequencers share one set of request and response inputs:
//   - a WORDS=4 instance (64-bit);
//   - a WORDS=1 instance (16-bit), which receives the low 16 bits of the
//     operands.
//
// Directed vectors carry hand-computed results. A short randomised section
// compares results against an arithmetic reference, including wide signed
// arithmetic for overflow.
// ---------------------------------------------------------------------------
module tb_cla_wide_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        op_i;
  logic [63:0] a_i;
  logic [63:0] b_i;
  logic        out_ready;

  logic        in_ready4, out_valid4, cout4, ovf4, busy4;
  logic [63:0] sum4;
  logic        in_ready1, out_valid1, cout1, ovf1, busy1;
  logic [15:0] sum1;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cla_wide_add_seq #(.WORDS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .op_sub(op_i), .a(a_i), .b(b_i), .out_valid(out_valid4),
    .out_ready(out_ready), .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
  );

  cla_wide_add_seq #(.WORDS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .op_sub(op_i), .a(a_i[15:0]), .b(b_i[15:0]), .out_valid(out_valid1),
    .out_ready(out_ready), .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model:
  //   - {cout, sum} is a + b, or a + ~b + 1 for subtract, taken at width W+1.
  //   - ovf is set when the exact signed result does not fit in W bits.
  task automatic model(input logic [63:0] x, input logic [63:0] y, input logic s,
                       output logic [63:0] es4, output logic ec4, output logic eo4,
                       output logic [15:0] es1, output logic ec1, output logic eo1);
    logic [64:0]        t;
    logic [16:0]        t1;
    logic signed [65:0] r;
    logic signed [17:0] r1;
    if (s) begin
      t  = {1'b0, x} + {1'b0, ~y} + 65'd1;
      t1 = {1'b0, x[15:0]} + {1'b0, ~y[15:0]} + 17'd1;
      r  = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
      r1 = $signed({{2{x[15]}}, x[15:0]}) - $signed({{2{y[15]}}, y[15:0]});
    end else begin
      t  = {1'b0, x} + {1'b0, y};
      t1 = {1'b0, x[15:0]} + {1'b0, y[15:0]};
      r  = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y});
      r1 = $signed({{2{x[15]}}, x[15:0]}) + $signed({{2{y[15]}}, y[15:0]});
    end
    es4 = t[63:0];
    ec4 = t[64];
    eo4 = (r[65:63] != 3'b000) && (r[65:63] != 3'b111);
    es1 = t1[15:0];
    ec1 = t1[16];
    eo1 = (r1[17:15] != 3'b000) && (r1[17:15] != 3'b111);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (!(in_ready4 && in_ready1) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("idle_rdy", 64'(in_ready4 & in_ready1), 64'd1);
  endtask

  task automatic do_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                       input logic ts,
                       input logic [63:0] es4, input logic ec4, input logic eo4,
                       input logic [15:0] es1, input logic ec1, input logic eo1,
                       input int hold);
    int c4 = -1;
    int c1 = -1;
    wait_idle();
    a_i = ta; b_i = tb_v; op_i = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 20 && c4 < 0; k++) begin
      @(posedge clk); #1;
      if (out_valid1 && c1 < 0) c1 = k;
      if (out_valid4 && c4 < 0) c4 = k;
    end
    chk({tag, "_lat4"}, 64'(c4), 64'd4);
    chk({tag, "_lat1"}, 64'(c1), 64'd1);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    chk({tag, "_sum4"},  sum4,        es4);
    chk({tag, "_cout4"}, 64'(cout4),  64'(ec4));
    chk({tag, "_ovf4"},  64'(ovf4),   64'(eo4));
    chk({tag, "_sum1"},  64'(sum1),   64'(es1));
    chk({tag, "_cout1"}, 64'(cout1),  64'(ec1));
    chk({tag, "_ovf1"},  64'(ovf1),   64'(eo1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb, es4;
    logic        rs, ec4, eo4, ec1, eo1;
    logic [15:0] es1;
    int          pulses;
    int          cyc;

    rst_n = 1'b0; in_valid = 1'b0; op_i = 1'b0; a_i = '0; b_i = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready4), 64'd1);
    chk("rst_out_valid", 64'(out_valid4), 64'd0);
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_sum", sum4, 64'd0);
    chk("rst_cout_ovf", 64'({cout4, ovf4}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    do_op("ripple", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0,
          64'h0001_0000_0000_0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    do_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
          64'h0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    do_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
          64'h8000_0000_0000_0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
    do_op("sovf16", 64'h7FFF, 64'h1, 1'b0,
          64'h8000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    do_op("sub_borrow", 64'h5, 64'h7, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0, 0);
    do_op("sub_ok", 64'h7, 64'h5, 1'b1,
          64'h2, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 0);
    do_op("sub_sovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 2);

    // Reset in the middle of RUN, after two slices have been processed
    wait_idle();
    a_i = 64'h1; b_i = 64'h1; op_i = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy4), 64'd1);
    chk("mid_partial_sum", sum4, 64'h2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", sum4, 64'd0);
    chk("mid_rst_flags", 64'({out_valid4, busy4, cout4, ovf4}), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready4), 64'd1);
    chk("mid_rst_u1", 64'({out_valid1, sum1}), 64'd0);
    #12;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid4) pulses++;
    end
    chk("mid_no_out", 64'(pulses), 64'd0);
    chk("mid_post_ready", 64'(in_ready4), 64'd1);

    // Backpressure while a new request is pending
    wait_idle();
    a_i = 64'h5; b_i = 64'h3; op_i = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid4 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_reach_done", 64'(out_valid4), 64'd1);
    a_i = 64'd10; b_i = 64'd20; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_sum_hold", sum4, 64'd8);
      chk("bp_flags_hold", 64'({out_valid4, in_ready4, cout4, ovf4}), 64'b1000);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle", 64'({in_ready4, out_valid4}), 64'b10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept", 64'(busy4), 64'd1);
    cyc = 0;
    while (!out_valid4 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_second_sum", sum4, 64'd30);
    chk("bp_second_cout", 64'(cout4), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Randomised operands with random response delay
    for (int n = 0; n < 300; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = ~ra;
        1: ra = {ra[63], {47{~ra[63]}}, ra[15:0]};
        default: ;
      endcase
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, es4, ec4, eo4, es1, ec1, eo1);
      do_op("rnd", ra, rb, rs, es4, ec4, eo4, es1, ec1, eo1, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
